// File: rtl/vending_ctrl_param.sv
// Parametrised vending controller: coin collection, drink selection, vend, greedy change.
// Optional per-drink stock tracking is enabled by defining VEND_STOCK_EN.
module vending_ctrl_param #(
    parameter int                            CREDIT_W   = 8,
    parameter int                            N_DRINKS   = 4,
    parameter int                            SEL_W      = 2,
    parameter logic [N_DRINKS*CREDIT_W-1:0]  PRICES     = 32'h1E19140F,
    parameter logic [CREDIT_W-1:0]           MAX_CREDIT = 8'd200
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin_code,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel_idx,
    input  logic                cancel,
`ifdef VEND_STOCK_EN
    input  logic                restock,
    input  logic [SEL_W-1:0]    restock_idx,
    input  logic [7:0]          restock_cnt,
    output logic [N_DRINKS-1:0] sold_out,
`endif
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                sel_reject,
    output logic                dispense_valid,
    output logic [SEL_W-1:0]    dispense_idx,
    output logic                change_valid,
    output logic [1:0]          change_code,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    state_t              state, state_nxt;
    logic [CREDIT_W-1:0] credit_nxt;
    logic [SEL_W-1:0]    vend_idx, vend_idx_nxt;
    logic                coin_reject_nxt, sel_reject_nxt;
    logic                dispense_valid_nxt, change_valid_nxt;
    logic [SEL_W-1:0]    dispense_idx_nxt;
    logic [1:0]          change_code_nxt, change_sel;
    logic                busy_nxt;

    logic [CREDIT_W:0]   coin_sum;
    logic                coin_fits;
    logic [CREDIT_W-1:0] vend_price;
    logic                sel_in_range, sel_in_stock, sel_ok;

    function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] idx);
        logic [CREDIT_W-1:0] p;
        p = '0;
        for (int i = 0; i < N_DRINKS; i++)
            if (idx == SEL_W'(i)) p = PRICES[i*CREDIT_W +: CREDIT_W];
        return p;
    endfunction

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
        logic [CREDIT_W-1:0] v;
        case (code)
            2'd0:    v = CREDIT_W'(1);
            2'd1:    v = CREDIT_W'(5);
            2'd2:    v = CREDIT_W'(10);
            default: v = CREDIT_W'(50);
        endcase
        return v;
    endfunction

    // Cap check one bit wider than credit so an overflowing coin cannot wrap past the cap.
    assign coin_sum     = {1'b0, credit} + {1'b0, coin_value(coin_code)};
    assign coin_fits    = coin_sum <= {1'b0, MAX_CREDIT};
    assign vend_price   = price_of(vend_idx);
    assign sel_in_range = int'(sel_idx) < N_DRINKS;
    assign sel_ok       = sel_in_range && (credit >= price_of(sel_idx)) && sel_in_stock;

    always_comb begin
        change_sel = 2'd0;
        if (credit >= CREDIT_W'(50))      change_sel = 2'd3;
        else if (credit >= CREDIT_W'(10)) change_sel = 2'd2;
        else if (credit >= CREDIT_W'(5))  change_sel = 2'd1;
    end

`ifdef VEND_STOCK_EN
    logic [7:0] stock     [N_DRINKS];
    logic [7:0] stock_nxt [N_DRINKS];

    always_comb begin
        sel_in_stock = 1'b0;
        for (int i = 0; i < N_DRINKS; i++)
            if (sel_idx == SEL_W'(i)) sel_in_stock = (stock[i] != 8'd0);
    end

    // Restocking is only honoured while idle; a vend consumes one unit of the latched drink.
    always_comb begin
        for (int i = 0; i < N_DRINKS; i++) stock_nxt[i] = stock[i];
        if (state == IDLE && restock) begin
            for (int i = 0; i < N_DRINKS; i++)
                if (restock_idx == SEL_W'(i)) stock_nxt[i] = restock_cnt;
        end
        if (state == VEND) begin
            for (int i = 0; i < N_DRINKS; i++)
                if (vend_idx == SEL_W'(i) && stock[i] != 8'd0) stock_nxt[i] = stock[i] - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_DRINKS; i++) begin
            if (reset) begin
                stock[i]    <= 8'd0;
                sold_out[i] <= 1'b1;
            end else begin
                stock[i]    <= stock_nxt[i];
                sold_out[i] <= (stock_nxt[i] == 8'd0);
            end
        end
    end
`else
    assign sel_in_stock = 1'b1;
`endif

    always_comb begin
        state_nxt          = state;
        credit_nxt         = credit;
        vend_idx_nxt       = vend_idx;
        coin_reject_nxt    = 1'b0;
        sel_reject_nxt     = 1'b0;
        dispense_valid_nxt = 1'b0;
        dispense_idx_nxt   = dispense_idx;
        change_valid_nxt   = 1'b0;
        change_code_nxt    = change_code;
        case (state)
            IDLE: begin
                sel_reject_nxt = sel_valid;
                if (coin_valid) begin
                    if (coin_fits) begin
                        credit_nxt = coin_sum[CREDIT_W-1:0];
                        state_nxt  = COLLECT;
                    end else begin
                        coin_reject_nxt = 1'b1;
                    end
                end
            end
            // Cancel beats selection beats coin; selection is judged on pre-coin credit.
            COLLECT: begin
                if (cancel) begin
                    coin_reject_nxt = coin_valid;
                    state_nxt       = (credit == '0) ? IDLE : CHANGE;
                end else if (sel_valid && sel_ok) begin
                    coin_reject_nxt = coin_valid;
                    vend_idx_nxt    = sel_idx;
                    state_nxt       = VEND;
                end else begin
                    sel_reject_nxt = sel_valid;
                    if (coin_valid) begin
                        if (coin_fits) credit_nxt = coin_sum[CREDIT_W-1:0];
                        else           coin_reject_nxt = 1'b1;
                    end
                end
            end
            VEND: begin
                coin_reject_nxt    = coin_valid;
                sel_reject_nxt     = sel_valid;
                dispense_valid_nxt = 1'b1;
                dispense_idx_nxt   = vend_idx;
                credit_nxt         = credit - vend_price;
                state_nxt          = (credit_nxt != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                coin_reject_nxt = coin_valid;
                sel_reject_nxt  = sel_valid;
                if (credit == '0) begin
                    state_nxt = IDLE;
                end else begin
                    change_valid_nxt = 1'b1;
                    change_code_nxt  = change_sel;
                    credit_nxt       = credit - coin_value(change_sel);
                    if (credit_nxt == '0) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy_nxt = (state_nxt == VEND) || (state_nxt == CHANGE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            credit         <= '0;
            vend_idx       <= '0;
            coin_reject    <= 1'b0;
            sel_reject     <= 1'b0;
            dispense_valid <= 1'b0;
            dispense_idx   <= '0;
            change_valid   <= 1'b0;
            change_code    <= 2'd0;
            busy           <= 1'b0;
        end else begin
            state          <= state_nxt;
            credit         <= credit_nxt;
            vend_idx       <= vend_idx_nxt;
            coin_reject    <= coin_reject_nxt;
            sel_reject     <= sel_reject_nxt;
            dispense_valid <= dispense_valid_nxt;
            dispense_idx   <= dispense_idx_nxt;
            change_valid   <= change_valid_nxt;
            change_code    <= change_code_nxt;
            busy           <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_vending_ctrl_param.sv
// Table-driven bench for vending_ctrl_param (SEL_W=3 so out-of-range selections are reachable).
// Stock sequence is exercised only when VEND_STOCK_EN is defined.
module tb_vending_ctrl_param;

    localparam int CREDIT_W = 8;
    localparam int N_DRINKS = 4;
    localparam int SEL_W    = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic                coin_valid;
    logic [1:0]          coin_code;
    logic                sel_valid;
    logic [SEL_W-1:0]    sel_idx;
    logic                cancel;
    logic [CREDIT_W-1:0] credit;
    logic                coin_reject, sel_reject, dispense_valid, change_valid, busy;
    logic [SEL_W-1:0]    dispense_idx;
    logic [1:0]          change_code;
`ifdef VEND_STOCK_EN
    logic                restock = 1'b0;
    logic [SEL_W-1:0]    restock_idx = '0;
    logic [7:0]          restock_cnt = 8'd0;
    logic [N_DRINKS-1:0] sold_out;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    vending_ctrl_param #(
        .CREDIT_W(CREDIT_W), .N_DRINKS(N_DRINKS), .SEL_W(SEL_W),
        .PRICES(32'h1E19140F), .MAX_CREDIT(8'd200)
    ) dut (
        .clk(clk), .reset(reset),
        .coin_valid(coin_valid), .coin_code(coin_code),
        .sel_valid(sel_valid), .sel_idx(sel_idx), .cancel(cancel),
`ifdef VEND_STOCK_EN
        .restock(restock), .restock_idx(restock_idx), .restock_cnt(restock_cnt),
        .sold_out(sold_out),
`endif
        .credit(credit), .coin_reject(coin_reject), .sel_reject(sel_reject),
        .dispense_valid(dispense_valid), .dispense_idx(dispense_idx),
        .change_valid(change_valid), .change_code(change_code), .busy(busy)
    );

    typedef struct {
        int cv, code, sv, idx, cn;
        int credit, crej, srej, dv, didx, chv, chc, busy;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(input int cv, code, sv, idx, cn,
                                   input int cr, crej, srej, dv, didx, chv, chc, bz);
        vec_t v;
        v = '{cv, code, sv, idx, cn, cr, crej, srej, dv, didx, chv, chc, bz};
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        n_compared++;
        if (act != exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input int cr, crej, srej, dv, didx, chv, chc, bz);
        checkOutput({tag, ".credit"},         int'(credit),         cr);
        checkOutput({tag, ".coin_reject"},    int'(coin_reject),    crej);
        checkOutput({tag, ".sel_reject"},     int'(sel_reject),     srej);
        checkOutput({tag, ".dispense_valid"}, int'(dispense_valid), dv);
        checkOutput({tag, ".dispense_idx"},   int'(dispense_idx),   didx);
        checkOutput({tag, ".change_valid"},   int'(change_valid),   chv);
        checkOutput({tag, ".change_code"},    int'(change_code),    chc);
        checkOutput({tag, ".busy"},           int'(busy),           bz);
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic applyStimulus(input int cv, code, sv, idx, cn);
        coin_valid = cv[0];
        coin_code  = code[1:0];
        sel_valid  = sv[0];
        sel_idx    = idx[SEL_W-1:0];
        cancel     = cn[0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        int waited;
        // cv code sv idx cn | credit crej srej dv didx chv chc busy
        addVec(1,2,0,0,0,  10,0,0,0,0,0,0,0);
        addVec(1,2,0,0,0,  20,0,0,0,0,0,0,0);
        addVec(0,0,1,1,0,  20,0,0,0,0,0,0,1);
        addVec(0,0,0,0,0,   0,0,0,1,1,0,0,0);
        addVec(0,0,0,0,0,   0,0,0,0,1,0,0,0);
        addVec(1,3,0,0,0,  50,0,0,0,1,0,0,0);
        addVec(1,1,0,0,0,  55,0,0,0,1,0,0,0);
        addVec(1,0,0,0,0,  56,0,0,0,1,0,0,0);
        addVec(0,0,1,0,0,  56,0,0,0,1,0,0,1);
        addVec(0,0,0,0,0,  41,0,0,1,0,0,0,1);
        addVec(0,0,0,0,0,  31,0,0,0,0,1,2,1);
        addVec(0,0,0,0,0,  21,0,0,0,0,1,2,1);
        addVec(0,0,0,0,0,  11,0,0,0,0,1,2,1);
        addVec(0,0,0,0,0,   1,0,0,0,0,1,2,1);
        addVec(0,0,0,0,0,   0,0,0,0,0,1,0,0);
        addVec(0,0,0,0,0,   0,0,0,0,0,0,0,0);
        addVec(1,2,0,0,0,  10,0,0,0,0,0,0,0);
        addVec(0,0,1,3,0,  10,0,1,0,0,0,0,0);
        addVec(0,0,0,0,0,  10,0,0,0,0,0,0,0);
        addVec(0,0,1,5,0,  10,0,1,0,0,0,0,0);
        addVec(0,0,1,4,0,  10,0,1,0,0,0,0,0);
        addVec(0,0,0,0,1,  10,0,0,0,0,0,0,1);
        addVec(0,0,0,0,0,   0,0,0,0,0,1,2,0);
        addVec(1,3,0,0,0,  50,0,0,0,0,0,2,0);
        addVec(1,3,0,0,0, 100,0,0,0,0,0,2,0);
        addVec(1,3,0,0,0, 150,0,0,0,0,0,2,0);
        addVec(1,3,0,0,0, 200,0,0,0,0,0,2,0);
        addVec(1,0,0,0,0, 200,1,0,0,0,0,2,0);
        addVec(0,0,0,0,1, 200,0,0,0,0,0,2,1);
        addVec(0,0,0,0,0, 150,0,0,0,0,1,3,1);
        addVec(0,0,0,0,0, 100,0,0,0,0,1,3,1);
        addVec(0,0,0,0,0,  50,0,0,0,0,1,3,1);
        addVec(0,0,0,0,0,   0,0,0,0,0,1,3,0);
        addVec(1,2,0,0,0,  10,0,0,0,0,0,3,0);
        addVec(1,2,0,0,0,  20,0,0,0,0,0,3,0);
        addVec(1,1,0,0,0,  25,0,0,0,0,0,3,0);
        addVec(1,3,0,0,1,  25,1,0,0,0,0,3,1);
        addVec(0,0,0,0,0,  15,0,0,0,0,1,2,1);
        addVec(1,2,0,0,0,   5,1,0,0,0,1,2,1);
        addVec(0,0,1,0,0,   0,0,1,0,0,1,1,0);
        addVec(0,0,0,0,0,   0,0,0,0,0,0,1,0);
        addVec(0,0,1,0,1,   0,0,1,0,0,0,1,0);
        addVec(1,3,0,0,0,  50,0,0,0,0,0,1,0);
        addVec(1,0,1,3,0,  50,1,0,0,0,0,1,1);
        addVec(1,0,0,0,0,  20,1,0,1,3,0,1,1);
        addVec(0,0,0,0,0,  10,0,0,0,3,1,2,1);
        addVec(0,0,0,0,0,   0,0,0,0,3,1,2,0);

        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkAll("reset", 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef VEND_STOCK_EN
        checkOutput("reset.sold_out", int'(sold_out), 15);
`endif
        reset = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].cv, vecs[i].code, vecs[i].sv, vecs[i].idx, vecs[i].cn);
            checkAll($sformatf("v%0d", i), vecs[i].credit, vecs[i].crej, vecs[i].srej,
                     vecs[i].dv, vecs[i].didx, vecs[i].chv, vecs[i].chc, vecs[i].busy);
        end

        // Reset while change is pending must drop the credit without ejecting anything.
        applyStimulus(1, 2, 0, 0, 0);
        applyStimulus(1, 2, 0, 0, 0);
        applyStimulus(1, 2, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        waited = 0;
        while (!busy && waited < 8) begin
            applyStimulus(0, 0, 0, 0, 0);
            waited++;
        end
        checkOutput("t6.busy_before_reset", int'(busy), 1);
        checkOutput("t6.credit_before_reset", int'(credit), 30);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        checkAll("t6.reset", 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        checkAll("t6.after", 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef VEND_STOCK_EN
        restock     = 1'b1;
        restock_idx = 3'd2;
        restock_cnt = 8'd1;
        applyStimulus(0, 0, 0, 0, 0);
        restock     = 1'b0;
        checkOutput("t7.sold_out_restocked", int'(sold_out), 11);
        applyStimulus(1, 3, 0, 0, 0);
        applyStimulus(0, 0, 1, 2, 0);
        checkOutput("t7.busy_vend", int'(busy), 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t7.dispense_valid", int'(dispense_valid), 1);
        checkOutput("t7.dispense_idx", int'(dispense_idx), 2);
        checkOutput("t7.credit", int'(credit), 25);
        checkOutput("t7.sold_out_empty", int'(sold_out), 15);
        repeat (3) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t7.credit_after_change", int'(credit), 0);
        applyStimulus(1, 3, 0, 0, 0);
        applyStimulus(0, 0, 1, 2, 0);
        checkOutput("t7.sel_reject_sold_out", int'(sel_reject), 1);
        checkOutput("t7.busy_sold_out", int'(busy), 0);
        checkOutput("t7.credit_kept", int'(credit), 50);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
